// File: rtl/xadc_drp_scheduler.sv
// Shares the XADC DRP between an EOS-triggered aux-channel scanner and a single-access host port.
// The scanner reduces aux channels 0-3 to a 2-bit argmax class gated by a threshold.
module xadc_drp_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [6:0]  AUX_BASE_ADDR  = 7'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eos,
  input  logic        drdy,
  input  logic [15:0] do_data,
  output logic [6:0]  daddr,
  output logic        den,
  output logic        dwe,
  output logic [15:0] di,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [6:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        host_err,
  input  logic [11:0] threshold,
  output logic [1:0]  network_output,
  output logic        result_valid,
  output logic        above_thresh,
  output logic        scan_overrun,
  output logic [47:0] ch_codes
);

  localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StScanIssue, StScanWait, StHostIssue, StHostWait, StDecide
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic            last_scan_q, last_scan_d;
  logic            hwe_q, hwe_d;
  logic [11:0]     code_q [4];
  logic [11:0]     code_d [4];
  logic [6:0]      daddr_q, daddr_d;
  logic            den_q, den_d, dwe_q, dwe_d;
  logic [15:0]     di_q, di_d;
  logic            ack_q, ack_d, err_q, err_d;
  logic [15:0]     rdata_q, rdata_d;
  logic [1:0]      net_q, net_d;
  logic            valid_q, valid_d, above_q, above_d, overrun_q, overrun_d;
  logic [47:0]     ch_codes_q, ch_codes_d;

  logic [11:0] max_code;
  logic [1:0]  max_idx;
  logic        grant_scan, timed_out;

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    max_code = code_q[0];
    max_idx  = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (code_q[i] > max_code) begin
        max_code = code_q[i];
        max_idx  = 2'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    last_scan_d = last_scan_q;
    hwe_d       = hwe_q;
    code_d      = code_q;
    daddr_d     = daddr_q;
    den_d       = 1'b0;
    dwe_d       = 1'b0;
    di_d        = di_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    net_d       = net_q;
    valid_d     = 1'b0;
    above_d     = above_q;
    ch_codes_d  = ch_codes_q;
    grant_scan  = 1'b0;
    timed_out   = (cnt_q == CntLast) && !drdy;

    unique case (state_q)
      StIdle: begin
        // A raw eos counts as a request so a same-cycle host_req is arbitrated fairly.
        if ((pending_q || eos) && (!host_req || !last_scan_q)) begin
          grant_scan  = 1'b1;
          last_scan_d = 1'b1;
          idx_d       = 2'd0;
          state_d     = StScanIssue;
        end else if (host_req) begin
          last_scan_d = 1'b0;
          state_d     = StHostIssue;
        end
      end
      StScanIssue: begin
        daddr_d = AUX_BASE_ADDR + {5'd0, idx_q};
        den_d   = 1'b1;
        cnt_d   = '0;
        state_d = StScanWait;
      end
      StScanWait: begin
        cnt_d = cnt_q + 1'b1;
        if (drdy || timed_out) begin
          code_d[idx_q] = drdy ? do_data[15:4] : 12'h000;
          if (idx_q == 2'd3) begin
            state_d = StDecide;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = StScanIssue;
          end
        end
      end
      StDecide: begin
        ch_codes_d = {code_q[3], code_q[2], code_q[1], code_q[0]};
        valid_d    = 1'b1;
        above_d    = (max_code >= threshold);
        if (max_code >= threshold) net_d = max_idx;
        state_d    = StIdle;
      end
      StHostIssue: begin
        daddr_d = host_addr;
        di_d    = host_wdata;
        dwe_d   = host_we;
        hwe_d   = host_we;
        den_d   = 1'b1;
        cnt_d   = '0;
        state_d = StHostWait;
      end
      StHostWait: begin
        cnt_d = cnt_q + 1'b1;
        if (drdy) begin
          if (!hwe_q) rdata_d = do_data;
          ack_d   = 1'b1;
          state_d = StIdle;
        end else if (timed_out) begin
          rdata_d = 16'hDEAD;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // One level of pending: a grant consumes the stored request, a fresh eos re-arms it.
    pending_d = grant_scan ? (pending_q && eos) : (pending_q || eos);
    overrun_d = eos && pending_q && !grant_scan;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      last_scan_q <= 1'b0;
      hwe_q       <= 1'b0;
      for (int i = 0; i < 4; i++) code_q[i] <= '0;
      daddr_q     <= '0;
      den_q       <= 1'b0;
      dwe_q       <= 1'b0;
      di_q        <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      net_q       <= '0;
      valid_q     <= 1'b0;
      above_q     <= 1'b0;
      overrun_q   <= 1'b0;
      ch_codes_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      last_scan_q <= last_scan_d;
      hwe_q       <= hwe_d;
      code_q      <= code_d;
      daddr_q     <= daddr_d;
      den_q       <= den_d;
      dwe_q       <= dwe_d;
      di_q        <= di_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      net_q       <= net_d;
      valid_q     <= valid_d;
      above_q     <= above_d;
      overrun_q   <= overrun_d;
      ch_codes_q  <= ch_codes_d;
    end
  end

  assign daddr          = daddr_q;
  assign den            = den_q;
  assign dwe            = dwe_q;
  assign di             = di_q;
  assign host_ack       = ack_q;
  assign host_err       = err_q;
  assign host_rdata     = rdata_q;
  assign network_output = net_q;
  assign result_valid   = valid_q;
  assign above_thresh   = above_q;
  assign scan_overrun   = overrun_q;
  assign ch_codes       = ch_codes_q;

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Directed bench for xadc_drp_scheduler: DRP responder model plus scan/host scoreboards.
module tb_xadc_drp_scheduler;

  localparam int Lat = 2;
  localparam int Tmo = 255;

  logic        clk = 1'b0, rst = 1'b1, eos = 1'b0, drdy = 1'b0;
  logic [15:0] do_data = '0;
  logic [6:0]  daddr;
  logic        den, dwe;
  logic [15:0] di;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [6:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_ack, host_err;
  logic [15:0] host_rdata;
  logic [11:0] threshold = '0;
  logic [1:0]  network_output;
  logic        result_valid, above_thresh, scan_overrun;
  logic [47:0] ch_codes;

  xadc_drp_scheduler #(.TIMEOUT_CYCLES(Tmo), .AUX_BASE_ADDR(7'h10)) dut (
    .clk(clk), .rst(rst), .eos(eos), .drdy(drdy), .do_data(do_data),
    .daddr(daddr), .den(den), .dwe(dwe), .di(di),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
    .threshold(threshold), .network_output(network_output), .result_valid(result_valid),
    .above_thresh(above_thresh), .scan_overrun(scan_overrun), .ch_codes(ch_codes)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] nout; logic above; logic [47:0] codes; } scan_exp_t;
  typedef struct packed { logic [15:0] rdata; logic err; } host_exp_t;
  scan_exp_t scan_q[$];
  host_exp_t host_q[$];

  int n_checks = 0, n_pass = 0, n_fail = 0;

  // DRP model state and activity log.
  logic [11:0] aux [4];
  logic        mute = 1'b0;
  logic [15:0] mem [128];
  bit          written [128];
  int          pend = 0;
  logic [6:0]  pend_addr = '0;
  logic [6:0]  rd_addr [256];
  int          rd_n = 0, cyc_p = 0, eos_cycle = 0, rv_cycle = 0, ack_cycle = 0, den_cycle = 0;
  int          rv_count = 0, ack_count = 0, ov_count = 0, dwe_stray = 0;
  logic        den_we = 1'b0;

  function automatic logic [15:0] dflt(input logic [6:0] a);
    return {a, 9'h0AB};
  endfunction

  // Cycle k is the interval after the k-th posedge; eos sampled there belongs to cycle k-1.
  always @(posedge clk) begin
    cyc_p++;
    if (eos) eos_cycle = cyc_p - 1;
  end

  always @(negedge clk) begin
    drdy = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0 && !mute) begin
        drdy = 1'b1;
        if (pend_addr >= 7'h10 && pend_addr <= 7'h13) do_data = {aux[pend_addr[1:0]], 4'h5};
        else if (written[pend_addr]) do_data = mem[pend_addr];
        else do_data = dflt(pend_addr);
      end
    end
    if (dwe && !den) dwe_stray++;
    if (den) begin
      pend_addr = daddr;
      pend      = Lat;
      den_cycle = cyc_p;
      den_we    = dwe;
      if (dwe) begin
        mem[daddr]     = di;
        written[daddr] = 1'b1;
      end
      if (rd_n < 256) rd_addr[rd_n] = daddr;
      rd_n++;
    end
    if (result_valid) begin rv_count++; rv_cycle = cyc_p; end
    if (host_ack) begin ack_count++; ack_cycle = cyc_p; end
    if (scan_overrun) ov_count++;
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs until the wanted number of scan results and host acks arrive, popping the scoreboards.
  task automatic service(input int budget, input int want_rv, input int want_ack);
    int got_rv = 0;
    int got_ack = 0;
    scan_exp_t se;
    host_exp_t he;
    for (int k = 0; k < budget && (got_rv < want_rv || got_ack < want_ack); k++) begin
      @(negedge clk);
      eos = 1'b0;
      if (result_valid) begin
        got_rv++;
        if (scan_q.size() == 0) check("scan_unexpected", 1, 0);
        else begin
          se = scan_q.pop_front();
          check("network_output", network_output, se.nout);
          check("above_thresh", above_thresh, se.above);
          check("ch_codes", ch_codes, se.codes);
        end
      end
      if (host_ack) begin
        got_ack++;
        host_req = 1'b0;
        mute     = 1'b0;
        if (host_q.size() == 0) check("ack_unexpected", 1, 0);
        else begin
          he = host_q.pop_front();
          check("host_rdata", host_rdata, he.rdata);
          check("host_err", host_err, he.err);
        end
      end
    end
    check("rv_seen", got_rv, want_rv);
    check("ack_seen", got_ack, want_ack);
    #1;
  endtask

  task automatic set_aux(input logic [11:0] c0, c1, c2, c3);
    aux[0] = c0; aux[1] = c1; aux[2] = c2; aux[3] = c3;
  endtask

  task automatic host_start(input logic we, input logic [6:0] a, input logic [15:0] wd);
    host_we = we; host_addr = a; host_wdata = wd; host_req = 1'b1;
  endtask

  int base, r0, a0, o0;

  initial begin
    set_aux(12'h0, 12'h0, 12'h0, 12'h0);
    repeat (3) @(negedge clk);
    check("reset_outputs", {daddr, den, dwe, di, host_ack, host_rdata, host_err, network_output,
          result_valid, above_thresh, scan_overrun, ch_codes}, 96'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic scan: winner is channel 1, addresses 0x10..0x13, eos-to-result latency.
    set_aux(12'h100, 12'h7FF, 12'h200, 12'h050);
    threshold = 12'h400;
    base = rd_n;
    scan_q.push_back('{nout: 2'd1, above: 1'b1, codes: 48'h050_200_7FF_100});
    @(negedge clk); eos = 1'b1;
    service(100, 1, 0);
    check("scan_latency", rv_cycle - eos_cycle, 4 * (2 + Lat) + 2);
    check("scan_addrs", {rd_addr[base], rd_addr[base+1], rd_addr[base+2], rd_addr[base+3]},
          {7'h10, 7'h11, 7'h12, 7'h13});

    // All-equal codes resolve to channel 0, single result pulse.
    set_aux(12'h123, 12'h123, 12'h123, 12'h123);
    threshold = 12'h100;
    r0 = rv_count;
    scan_q.push_back('{nout: 2'd0, above: 1'b1, codes: 48'h123_123_123_123});
    @(negedge clk); eos = 1'b1;
    service(100, 1, 0);
    repeat (20) @(negedge clk);
    #1 check("rv_once", rv_count - r0, 1);

    // Establish class 2, then a below-threshold scan must keep it.
    set_aux(12'h010, 12'h020, 12'h900, 12'h030);
    threshold = 12'h400;
    scan_q.push_back('{nout: 2'd2, above: 1'b1, codes: 48'h030_900_020_010});
    @(negedge clk); eos = 1'b1;
    service(100, 1, 0);
    set_aux(12'h0FF, 12'h010, 12'h020, 12'h030);
    scan_q.push_back('{nout: 2'd2, above: 1'b0, codes: 48'h030_020_010_0FF});
    @(negedge clk); eos = 1'b1;
    service(100, 1, 0);

    // Lone host read leaves last grant with the host.
    host_q.push_back('{rdata: 16'h82AB, err: 1'b0});
    @(negedge clk); host_start(1'b0, 7'h41, 16'h0);
    service(100, 0, 1);

    // Contention after a host grant: scan goes first, one ack.
    set_aux(12'h100, 12'h7FF, 12'h200, 12'h050);
    a0 = ack_count;
    scan_q.push_back('{nout: 2'd1, above: 1'b1, codes: 48'h050_200_7FF_100});
    host_q.push_back('{rdata: 16'h82AB, err: 1'b0});
    @(negedge clk); eos = 1'b1; host_start(1'b0, 7'h41, 16'h0);
    service(200, 1, 1);
    check("scan_before_host", rv_cycle < ack_cycle, 1'b1);
    repeat (10) @(negedge clk);
    #1 check("single_ack", ack_count - a0, 1);

    // Lone scan, then contention after a scan grant: host goes first.
    scan_q.push_back('{nout: 2'd1, above: 1'b1, codes: 48'h050_200_7FF_100});
    @(negedge clk); eos = 1'b1;
    service(100, 1, 0);
    scan_q.push_back('{nout: 2'd1, above: 1'b1, codes: 48'h050_200_7FF_100});
    host_q.push_back('{rdata: 16'h82AB, err: 1'b0});
    @(negedge clk); eos = 1'b1; host_start(1'b0, 7'h41, 16'h0);
    service(200, 1, 1);
    check("host_before_scan", ack_cycle < rv_cycle, 1'b1);

    // Host write with no drdy times out; a following scan is unaffected.
    mute = 1'b1;
    host_q.push_back('{rdata: 16'hDEAD, err: 1'b1});
    @(negedge clk); host_start(1'b1, 7'h49, 16'h1234);
    service(400, 0, 1);
    check("timeout_latency", ack_cycle - den_cycle, Tmo);
    check("write_dwe", den_we, 1'b1);
    set_aux(12'h123, 12'h123, 12'h123, 12'h123);
    threshold = 12'h100;
    scan_q.push_back('{nout: 2'd0, above: 1'b1, codes: 48'h123_123_123_123});
    @(negedge clk); eos = 1'b1;
    service(100, 1, 0);

    // Successful write keeps host_rdata; read-back returns the written data.
    host_q.push_back('{rdata: 16'hDEAD, err: 1'b0});
    @(negedge clk); host_start(1'b1, 7'h49, 16'hBEEF);
    service(100, 0, 1);
    host_q.push_back('{rdata: 16'hBEEF, err: 1'b0});
    @(negedge clk); host_start(1'b0, 7'h49, 16'h0);
    service(100, 0, 1);

    // Two eos while the host holds the DRP: one overrun, exactly one scan.
    set_aux(12'h010, 12'h020, 12'h900, 12'h030);
    threshold = 12'h400;
    o0 = ov_count;
    r0 = rv_count;
    mute = 1'b1;
    host_q.push_back('{rdata: 16'hDEAD, err: 1'b1});
    scan_q.push_back('{nout: 2'd2, above: 1'b1, codes: 48'h030_900_020_010});
    @(negedge clk); host_start(1'b1, 7'h4A, 16'h0001);
    repeat (5) @(negedge clk);
    eos = 1'b1;
    @(negedge clk); eos = 1'b0;
    repeat (3) @(negedge clk);
    eos = 1'b1;
    service(400, 1, 1);
    repeat (40) @(negedge clk);
    #1;
    check("overrun_count", ov_count - o0, 1);
    check("one_scan", rv_count - r0, 1);
    check("no_stray_dwe", dwe_stray, 0);

    // Reset in the middle of a scan read: everything clears, no result.
    r0 = rv_count;
    @(negedge clk); eos = 1'b1;
    @(negedge clk); eos = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 check("midscan_reset", {daddr, den, dwe, di, host_ack, host_rdata, host_err, network_output,
             result_valid, above_thresh, scan_overrun, ch_codes}, 96'h0);
    @(negedge clk); rst = 1'b0;
    repeat (40) @(negedge clk);
    #1 check("no_result_after_reset", rv_count - r0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xadc_drp_scheduler.md
Name: xadc_drp_scheduler

Overview:
- Sequences and shares the XADC dynamic reconfiguration port (DRP) between two requesters.
- Requester 1 is an automatic scanner: on each end-of-sequence (EOS) it reads aux channels 0-3 and reduces them to a 2-bit winning class on network_output.
- Requester 2 is a host port: a single read or write, driven by the AXI config-register block for debug and reconfiguration.
- Sits between the config regs, the XADC primitive, and the LED/analyzer logic.

Parameters:
TIMEOUT_CYCLES, 255, max cycles to wait for drdy after a den pulse before the access is aborted
AUX_BASE_ADDR, 7'h10, DRP address of aux channel 0 result; channels 1-3 are at +1, +2, +3

Ports:
clk  in  1  DRP clock (same as XADC DCLK)
rst  in  1  asynchronous, active-high reset
eos  in  1  XADC end-of-sequence pulse
drdy  in  1  XADC DRP data ready
do_data  in  16  XADC DRP read data
daddr  out  7  DRP address
den  out  1  DRP enable, one-cycle pulse
dwe  out  1  DRP write enable, asserted only together with den
di  out  16  DRP write data
host_req  in  1  host access request; held high until host_ack
host_we  in  1  1 = write, 0 = read
host_addr  in  7  host DRP address
host_wdata  in  16  host write data
host_ack  out  1  one-cycle pulse; host access complete
host_rdata  out  16  read data, valid with host_ack, held until next ack
host_err  out  1  one-cycle pulse with host_ack when the access timed out
threshold  in  12  minimum winning code for a valid classification
network_output  out  2  index of winning aux channel
result_valid  out  1  one-cycle pulse; scan decision made
above_thresh  out  1  with result_valid: max code >= threshold
scan_overrun  out  1  one-cycle pulse; eos arrived while a scan was already pending
ch_codes  out  48  {ch3,ch2,ch1,ch0} 12-bit codes from the last completed scan

Behaviour:
- Reset values: all outputs 0; state IDLE; scan_pending = 0; last_grant = host.
- eos sets scan_pending.
  - If scan_pending is already 1 (scan not yet started), pulse scan_overrun.
  - Pending depth is one level; eos during an active scan sets scan_pending without overrun.
- States: IDLE, SCAN_ISSUE, SCAN_WAIT, HOST_ISSUE, HOST_WAIT, DECIDE.
- IDLE arbitration:
  - Only scan_pending set: grant the scanner.
  - Only host_req set: grant the host.
  - Both set: grant the requester not in last_grant (alternating); update last_grant.
  - A scan is atomic (4 reads); the host is never inserted mid-scan.
- SCAN_ISSUE:
  - Clear scan_pending on entry to channel 0.
  - daddr = AUX_BASE_ADDR + idx, den = 1 for one cycle, dwe = 0.
  - Next state: SCAN_WAIT.
- SCAN_WAIT:
  - On drdy, latch do_data[15:4] into code[idx].
  - If idx < 3: idx+1, go to SCAN_ISSUE. If idx = 3: go to DECIDE.
  - Timeout: code[idx] = 0, continue as if drdy.
- DECIDE (1 cycle):
  - Argmax over code[0..3], unsigned 12-bit compare; ties resolve to the lowest index.
  - Next cycle: update ch_codes, update network_output only if max >= threshold, pulse result_valid, set above_thresh = (max >= threshold).
  - Return to IDLE.
- HOST_ISSUE:
  - daddr = host_addr, di = host_wdata, dwe = host_we, den = 1 for one cycle.
  - Next state: HOST_WAIT.
- HOST_WAIT:
  - On drdy: host_rdata = do_data (write: unchanged), pulse host_ack, go to IDLE.
  - Timeout: pulse host_ack and host_err, host_rdata = 16'hDEAD, go to IDLE.
- Timeout counter: 8+ bits, cleared at each den; fires when count reaches TIMEOUT_CYCLES with no drdy.
- drdy outside a WAIT state is ignored.
- den is never reissued while busy is high; ISSUE states hold until busy = 0.
- Host requester must drop host_req the cycle after host_ack; a still-high host_req is treated as a new request.
- Latency, uncontended scan: eos → result_valid = 4×(2 + drdy latency) + 2 cycles.
- rst asserted mid-operation: immediate return to reset values; no ack or result is emitted for the aborted transaction.

Test Plan:
- Codes 0x100, 0x7FF, 0x200, 0x050; threshold 0x400; pulse eos → four reads at 0x10-0x13, network_output = 1, above_thresh = 1, ch_codes match.
- Codes all 0x123; threshold 0x100 → network_output = 0 (tie resolves to lowest index), result_valid pulses once.
- Max code 0x0FF < threshold 0x400, previous network_output = 2 → network_output stays 2, result_valid = 1, above_thresh = 0.
- host_req and eos asserted in the same cycle with last_grant = host → scan completes first, then host read of 0x41 returns the model value with a single host_ack; repeat with last_grant = scan → host served first.
- Host write to 0x49 with no drdy → host_ack and host_err at den + TIMEOUT_CYCLES, host_rdata = 0xDEAD, next scan proceeds normally.
- Two eos pulses before a scan starts (host busy) → one scan_overrun pulse, exactly one scan; also assert rst during SCAN_WAIT → all outputs 0, no result_valid.
